// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin sharing of one external ALU between two valid/ready requesters
// Ports:
//   clk, reset_n                 clock, asynchronous active-low reset
//   req{0,1}_valid/ready         request handshake; ready is combinational, high only in IDLE
//   req{0,1}_ctl/a/b             request op and operands, latched on accept
//   rsp{0,1}_valid/ready         response handshake; only the owner's valid rises
//   rsp{0,1}_result/zero         captured ALU result and zero flag
//   alu_ctl/alu_a/alu_b          latched op driven to the external ALU (held between ops)
//   alu_out/alu_zero             combinational ALU result, captured at the end of EXEC
module alu_share_arbiter #(
  parameter int DATA_W = 32,
  parameter int CTL_W  = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [CTL_W-1:0]  req0_ctl,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic [DATA_W-1:0] rsp0_result,
  output logic              rsp0_zero,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [CTL_W-1:0]  req1_ctl,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [DATA_W-1:0] rsp1_result,
  output logic              rsp1_zero,
  output logic [CTL_W-1:0]  alu_ctl,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              alu_zero
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t             state;
  logic               last_grant;
  logic               owner;
  logic [CTL_W-1:0]   op_ctl;
  logic [DATA_W-1:0]  op_a;
  logic [DATA_W-1:0]  op_b;
  logic [DATA_W-1:0]  result;
  logic               zero;
  logic               grant0;
  logic               grant1;
  // On a tie the port that did not win last time is granted
  always_comb begin
    grant0 = req0_valid & (~req1_valid | last_grant);
    grant1 = req1_valid & (~req0_valid | ~last_grant);
  end
  assign req0_ready  = (state == IDLE) & grant0;
  assign req1_ready  = (state == IDLE) & grant1;
  assign rsp0_valid  = (state == RESP) & ~owner;
  assign rsp1_valid  = (state == RESP) & owner;
  assign rsp0_result = result;
  assign rsp1_result = result;
  assign rsp0_zero   = zero;
  assign rsp1_zero   = zero;
  assign alu_ctl     = op_ctl;
  assign alu_a       = op_a;
  assign alu_b       = op_b;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      owner      <= 1'b0;
      op_ctl     <= '0;
      op_a       <= '0;
      op_b       <= '0;
      result     <= '0;
      zero       <= 1'b0;
    end else begin
      case (state)
        IDLE: if (req0_ready | req1_ready) begin
          op_ctl     <= req1_ready ? req1_ctl : req0_ctl;
          op_a       <= req1_ready ? req1_a : req0_a;
          op_b       <= req1_ready ? req1_b : req0_b;
          owner      <= req1_ready;
          last_grant <= req1_ready;
          state      <= EXEC;
        end
        EXEC: begin
          result <= alu_out;
          zero   <= alu_zero;
          state  <= RESP;
        end
        RESP: if (owner ? rsp1_ready : rsp0_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter: scoreboard bench with a behavioural ALU/arbiter model and randomized traffic
module tb_alu_share_arbiter;
  logic        clk = 0;
  logic        reset_n = 0;
  logic        req0_valid = 0, req1_valid = 0;
  logic        req0_ready, req1_ready;
  logic [3:0]  req0_ctl = 0, req1_ctl = 0;
  logic [31:0] req0_a = 0, req0_b = 0, req1_a = 0, req1_b = 0;
  logic        rsp0_valid, rsp1_valid;
  logic        rsp0_ready = 0, rsp1_ready = 0;
  logic [31:0] rsp0_result, rsp1_result;
  logic        rsp0_zero, rsp1_zero;
  logic [3:0]  alu_ctl;
  logic [31:0] alu_a, alu_b, alu_out;
  logic        alu_zero;

  always #5 clk = ~clk;

  alu_share_arbiter dut (
    .clk(clk), .reset_n(reset_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_ctl(req0_ctl), .req0_a(req0_a), .req0_b(req0_b),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_result(rsp0_result), .rsp0_zero(rsp0_zero),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_ctl(req1_ctl), .req1_a(req1_a), .req1_b(req1_b),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_result(rsp1_result), .rsp1_zero(rsp1_zero),
    .alu_ctl(alu_ctl), .alu_a(alu_a), .alu_b(alu_b), .alu_out(alu_out), .alu_zero(alu_zero)
  );

  function automatic logic [31:0] ref_alu(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    case (c)
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0010: return a + b;
      4'b0110: return a - b;
      4'b0111: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  always_comb begin
    alu_out  = ref_alu(alu_ctl, alu_a, alu_b);
    alu_zero = (alu_out == 32'd0);
  end

  typedef struct { logic [3:0] ctl; logic [31:0] a; logic [31:0] b; } req_t;
  typedef struct { logic port; logic [31:0] res; logic z; int cyc; } exp_t;

  req_t  pq0[$], pq1[$];
  exp_t  sb[$], gseq[$];
  int    checks = 0, passes = 0, cyc = 0;
  int    rmode0 = 0, rmode1 = 0;
  logic  gap_en = 0;
  logic  mlast = 1;
  logic [31:0] lr;
  logic  lz;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", n, act, exp, $time);
  endtask

  task automatic fail(input string n);
    checks++;
    $display("FAIL %s: timed out (t=%0t)", n, $time);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    rsp0_ready = rmode0 == 0 ? 1'b1 : rmode0 == 1 ? 1'($urandom_range(0, 1)) : 1'b0;
    rsp1_ready = rmode1 == 0 ? 1'b1 : rmode1 == 1 ? 1'($urandom_range(0, 1)) : 1'b0;
  end

  initial forever begin
    int t;
    if (pq0.size() == 0) begin
      req0_valid = 0;
      wait (pq0.size() > 0);
      @(posedge clk); #1;
    end
    req0_ctl = pq0[0].ctl; req0_a = pq0[0].a; req0_b = pq0[0].b; req0_valid = 1;
    t = 0;
    do begin @(negedge clk); t++; end while (!(req0_ready && reset_n) && t < 300);
    if (t >= 300) fail("req0_handshake");
    @(posedge clk); #1;
    void'(pq0.pop_front());
    if (gap_en) begin
      req0_valid = 0;
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end
  end

  initial forever begin
    int t;
    if (pq1.size() == 0) begin
      req1_valid = 0;
      wait (pq1.size() > 0);
      @(posedge clk); #1;
    end
    req1_ctl = pq1[0].ctl; req1_a = pq1[0].a; req1_b = pq1[0].b; req1_valid = 1;
    t = 0;
    do begin @(negedge clk); t++; end while (!(req1_ready && reset_n) && t < 300);
    if (t >= 300) fail("req1_handshake");
    @(posedge clk); #1;
    void'(pq1.pop_front());
    if (gap_en) begin
      req1_valid = 0;
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end
  end

  // Acceptance model: decides which port should be granted and pushes the expected response
  always @(negedge clk) begin
    logic busy, e0, e1;
    exp_t e;
    if (!reset_n) begin
      sb.delete();
      mlast = 1;
    end else begin
      busy = sb.size() > 0;
      e0 = !busy && req0_valid && (!req1_valid || mlast);
      e1 = !busy && req1_valid && (!req0_valid || !mlast);
      chk("req0_ready", 32'(req0_ready), 32'(e0));
      chk("req1_ready", 32'(req1_ready), 32'(e1));
      if (e0 || e1) begin
        e.port = e1;
        e.res  = e1 ? ref_alu(req1_ctl, req1_a, req1_b) : ref_alu(req0_ctl, req0_a, req0_b);
        e.z    = (e.res == 0);
        e.cyc  = cyc;
        sb.push_back(e);
        gseq.push_back(e);
        mlast = e1;
      end
    end
  end

  // Response monitor: the head of the scoreboard is due two cycles after its accept
  always @(negedge clk) begin
    logic v0, v1;
    #1;
    if (reset_n) begin
      v0 = sb.size() > 0 && sb[0].port == 0 && cyc >= sb[0].cyc + 2;
      v1 = sb.size() > 0 && sb[0].port == 1 && cyc >= sb[0].cyc + 2;
      chk("rsp0_valid", 32'(rsp0_valid), 32'(v0));
      chk("rsp1_valid", 32'(rsp1_valid), 32'(v1));
      if (v0 || v1) begin
        chk("rsp_result", v1 ? rsp1_result : rsp0_result, sb[0].res);
        chk("rsp_zero", 32'(v1 ? rsp1_zero : rsp0_zero), 32'(sb[0].z));
        if (v1 ? rsp1_ready : rsp0_ready) begin
          lr = sb[0].res; lz = sb[0].z;
          void'(sb.pop_front());
        end
      end
    end
  end

  task automatic wait_idle();
    int t = 0;
    while ((pq0.size() > 0 || pq1.size() > 0 || sb.size() > 0) && t < 3000) begin
      @(negedge clk); t++;
    end
    if (t >= 3000) fail("wait_idle");
    @(negedge clk); #2;
  endtask

  task automatic push(input logic p, input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    req_t r;
    r.ctl = c; r.a = a; r.b = b;
    if (p) pq1.push_back(r); else pq0.push_back(r);
  endtask

  initial begin
    logic [3:0] ops [6];
    int t, n;
    ops = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1111};
    #1;
    chk("reset_req0_ready", 32'(req0_ready), 0);
    chk("reset_req1_ready", 32'(req1_ready), 0);
    chk("reset_rsp0_valid", 32'(rsp0_valid), 0);
    chk("reset_rsp1_valid", 32'(rsp1_valid), 0);
    chk("reset_alu_ctl", 32'(alu_ctl), 0);
    chk("reset_alu_a", alu_a, 0);
    chk("reset_alu_b", alu_b, 0);
    repeat (2) @(posedge clk);
    #3 reset_n = 1;

    push(0, 4'b0010, 5, 7);
    wait_idle();
    chk("add_5_7_result", lr, 12);
    chk("add_5_7_zero", 32'(lz), 0);

    push(0, 4'b0010, 1, 1);
    t = 0;
    do begin @(negedge clk); t++; end while (!req0_ready && t < 50);
    if (t >= 50) fail("midexec_accept");
    @(posedge clk); #3;
    reset_n = 0;
    #1;
    chk("midreset_req0_ready", 32'(req0_ready), 0);
    chk("midreset_req1_ready", 32'(req1_ready), 0);
    chk("midreset_rsp0_valid", 32'(rsp0_valid), 0);
    chk("midreset_rsp1_valid", 32'(rsp1_valid), 0);
    chk("midreset_alu_a", alu_a, 0);
    repeat (2) @(posedge clk);
    #3 reset_n = 1;
    repeat (4) @(negedge clk);
    #2;

    n = gseq.size();
    push(0, 4'b0110, 9, 9);
    push(1, 4'b0111, 3, 4);
    wait_idle();
    chk("tie_first_port", 32'(gseq[n].port), 0);
    chk("tie_first_zero", 32'(gseq[n].z), 1);
    chk("tie_second_port", 32'(gseq[n+1].port), 1);
    chk("slt_3_4_result", lr, 1);

    rmode1 = 2;
    push(1, 4'b0010, 100, 23);
    t = 0;
    do begin @(negedge clk); t++; end while (!rsp1_valid && t < 20);
    if (t >= 20) fail("backpressure_valid");
    push(0, 4'b0001, 32'hf0, 32'h0f);
    repeat (5) begin
      @(negedge clk); #2;
      chk("bp_rsp1_valid", 32'(rsp1_valid), 1);
      chk("bp_rsp1_result", rsp1_result, 123);
      chk("bp_req0_ready", 32'(req0_ready), 0);
    end
    rmode1 = 0;
    wait_idle();
    chk("bp_followup_or", lr, 32'hff);

    push(1, 4'b1111, 5, 3);
    wait_idle();
    chk("undef_ctl_result", lr, 0);
    chk("undef_ctl_zero", 32'(lz), 1);

    gseq.delete();
    for (int i = 0; i < 4; i++) begin
      push(0, 4'b0010, i, 1);
      push(1, 4'b0110, 10, i);
    end
    wait_idle();
    chk("fair_count", gseq.size(), 8);
    for (int i = 1; i < gseq.size(); i++) begin
      chk("fair_alternate", 32'(gseq[i].port), 32'(!gseq[i-1].port));
      chk("fair_spacing", gseq[i].cyc - gseq[i-1].cyc, 3);
    end

    gap_en = 1; rmode0 = 1; rmode1 = 1;
    for (int i = 0; i < 30; i++) begin
      for (int p = 0; p < 2; p++) begin
        logic [31:0] a;
        a = $urandom;
        push(p[0], ops[$urandom_range(0, 5)], a, ($urandom_range(0, 3) == 0) ? a : $urandom);
      end
    end
    wait_idle();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
